tdm_demux16: RTL and testbench
==============================

// Module: tdm_demux16
// PURPOSE
//  Receive end of the 16-lane time-division link: takes the 1-bit serial stream produced by the
//  16:1 select path (slot i carries datain[i]) and rebuilds the 16-bit parallel word.
//  Slot counter, frame-start alignment, gap tolerance, abort detection and a one-cycle
//  word-valid strobe. Sits between the serial link and the parallel consumer.
// PARAMETERS
//  LANES  16  number of slots per frame = output word width
//  SEL_W  4   slot index width, $clog2(LANES)
// PORTS
//  clk          in   1      single clock, rising edge
//  rst          in   1      synchronous, active-high reset
//  din          in   1      serial data bit for current slot
//  din_valid    in   1      din is sampled only when high
//  frame_start  in   1      qualified by din_valid; marks slot 0 of a frame
//  s            out  SEL_W  slot index expected for the next accepted bit
//  dataout      out  LANES  last complete word; bit i = slot i
//  dout_valid   out  1      one-cycle strobe, dataout updated
//  frame_err    out  1      one-cycle strobe, frame aborted or failed check
// BEHAVIOUR
//  Reset (sync, rst=1 at posedge): state=IDLE, s=0, dataout=0, dout_valid=0, frame_err=0, shift reg=0.
//  FSM: IDLE -> COLLECT on din_valid&frame_start (bit stored in slot 0, s<=1).
//    IDLE: din_valid without frame_start is ignored, no error.
//    COLLECT: each din_valid stores din at slot s, s<=s+1; din_valid=0 holds (gaps unlimited).
//    Accepting slot LANES-1: COLLECT -> IDLE (or PARITY if enabled), s<=0.
//  Word commit: dataout registered with all LANES bits, dout_valid=1 the cycle after the
//    slot-15 bit is sampled (latency 1 clk); dataout holds until the next successful commit.
//  frame_start with din_valid while in COLLECT/PARITY: current frame dropped, frame_err=1 next
//    cycle, this bit becomes slot 0 of the new frame (s<=1); dataout unchanged.
//  frame_start on the slot-15 bit of a frame that is in progress counts as an abort (same as above).
//  Slot counter never wraps silently: wrap occurs only on commit/abort.
//  dout_valid and frame_err are never high in the same cycle except with PARITY_CHECK_EN (never).
//  Reset mid-frame: partial word discarded, no strobes, dataout cleared to 0.
// CONFIGURATION
//  PARITY_CHECK_EN defined: frame = 16 data slots + 1 parity slot (even parity over the 16 bits).
//    After slot 15 FSM enters PARITY; next din_valid bit compared. Match -> commit, dout_valid
//    the following cycle. Mismatch -> no commit, frame_err=1, dataout unchanged. s reads LANES
//    (saturated to LANES-1 in SEL_W bits) while in PARITY; frame_start in PARITY = abort.
//  Not defined: no PARITY state, commit directly after slot 15 as above.
// STRUCTURE
//  Shared package tdm_pkg: LANES, SEL_W localparams; state enum {IDLE, COLLECT, PARITY}.
//  One sub-module: tdm_slot_counter (SEL_W-bit counter with clear, load-1, increment, last-slot flag).
//  Top holds FSM, shift/assembly register, output registers.
// TESTING
//  1 rst 2 clks; send 16'h000F slots 0..15 back-to-back, frame_start on slot 0 -> dataout=16'h000F,
//    dout_valid high exactly 1 clk, 1 clk after slot-15 bit; s back to 0.
//  2 send 16'h001E with din_valid low 3 clks between every slot -> dataout=16'h001E, one strobe.
//  3 send slots 0..7 of 16'hFFFF, then frame_start + 16'h00AA -> frame_err 1 clk, then
//    dataout=16'h00AA; no dout_valid for the aborted frame.
//  4 din_valid bits with no frame_start in IDLE -> s stays 0, no strobes, dataout unchanged.
//  5 rst asserted after slot 9 of 16'h1234 -> dataout=0, s=0, no strobes; new frame 16'h5678 decodes.
//  6 PARITY_CHECK_EN: 16'h000F + parity 0 -> commit; 16'h0007 + parity 0 -> frame_err, dataout=16'h000F.
//  Self-check: scoreboard compares dataout against sent word on every dout_valid.

Source files
------------

// File: rtl/tdm_pkg.sv
// tdm_pkg: shared slot widths and receive FSM states for the TDM link
package tdm_pkg;
   localparam int LANES = 16;
   localparam int SEL_W = $clog2(LANES);
   typedef enum logic [1:0] {IDLE, COLLECT, PARITY} state_t;
endpackage

// File: rtl/tdm_slot_counter.sv
// tdm_slot_counter: slot index with clear, load-1, increment and last-slot flag
module tdm_slot_counter
   import tdm_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             load1,
   input  logic             inc,
   output logic [SEL_W-1:0] cnt,
   output logic             last
);
   assign last = cnt == SEL_W'(LANES - 1);
   always_ff @(posedge clk)
      if (rst || clr) cnt <= '0;
      else if (load1) cnt <= SEL_W'(1);
      else if (inc) cnt <= cnt + 1'b1;
endmodule

// File: rtl/tdm_demux16.sv
// tdm_demux16: rebuilds 16-bit words from the serial TDM stream with abort detection.
// Defining PARITY_CHECK_EN adds an even-parity slot after slot 15.
module tdm_demux16
   import tdm_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             din,
   input  logic             din_valid,
   input  logic             frame_start,
   output logic [SEL_W-1:0] s,
   output logic [LANES-1:0] dataout,
   output logic             dout_valid,
   output logic             frame_err
);
   state_t state, state_nx;
   logic [SEL_W-1:0] cnt;
   logic last, start, take, abort, commit, bad, clr;
   logic [LANES-1:0] shreg, word, commit_word;

   tdm_slot_counter u_cnt (
      .clk(clk),
      .rst(rst),
      .clr(clr),
      .load1(start),
      .inc(take && !last),
      .cnt(cnt),
      .last(last)
   );

   always_ff @(posedge clk)
      state <= rst ? IDLE : state_nx;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = start ? COLLECT : IDLE;
`ifdef PARITY_CHECK_EN
         COLLECT: state_nx = take && last ? PARITY : COLLECT;
         PARITY:  state_nx = start ? COLLECT : din_valid ? IDLE : PARITY;
`else
         COLLECT: state_nx = take && last ? IDLE : COLLECT;
`endif
         default: state_nx = IDLE;
      endcase
   end

   // Bits above the current slot are zero, so the incoming bit can simply be OR-ed in.
   always_comb begin
      start = din_valid && frame_start;
      take  = din_valid && !frame_start && state == COLLECT;
      abort = start && state != IDLE;
      word  = shreg | (LANES'(din) << cnt);
      s     = cnt;
`ifdef PARITY_CHECK_EN
      clr         = din_valid && !frame_start && state == PARITY;
      commit      = clr && din == ^shreg;
      bad         = clr && din != ^shreg;
      commit_word = shreg;
`else
      commit      = take && last;
      bad         = 1'b0;
      clr         = commit;
      commit_word = word;
`endif
   end

   always_ff @(posedge clk)
      if (rst) begin
         shreg      <= '0;
         dataout    <= '0;
         dout_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         dout_valid <= commit;
         frame_err  <= abort || bad;
         if (start) shreg <= LANES'(din);
         else if (take) shreg <= word;
         if (commit) dataout <= commit_word;
      end
endmodule

// File: tb/tb_tdm_demux16.sv
// tb_tdm_demux16: scoreboard bench for tdm_demux16 (parity test runs when PARITY_CHECK_EN is defined)
module tb_tdm_demux16;
`ifdef PARITY_CHECK_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif
   logic clk = 0, rst = 1, din = 0, din_valid = 0, frame_start = 0;
   logic [3:0] s;
   logic [15:0] dataout, e;
   logic dout_valid, frame_err;
   int checks = 0, errors = 0, dv_cnt = 0, fe_cnt = 0;
   logic [15:0] exp_q[$];

   always #5 clk = ~clk;

   tdm_demux16 dut (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .frame_start(frame_start),
      .s(s), .dataout(dataout), .dout_valid(dout_valid), .frame_err(frame_err)
   );

   always @(negedge clk) begin
      if (dout_valid === 1'b1) begin
         dv_cnt++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: unexpected dout_valid, dataout=%h", dataout);
         end else begin
            e = exp_q.pop_front();
            if (dataout !== e) begin
               errors++;
               $display("FAIL scoreboard: dataout=%h required %h", dataout, e);
            end
         end
         if (frame_err !== 1'b0) begin
            errors++;
            $display("FAIL strobe_overlap: frame_err=%b required 0 with dout_valid", frame_err);
         end
      end
      if (frame_err === 1'b1) fe_cnt++;
   end

   task automatic put(input logic v, input logic d, input logic fs);
      din_valid = v;
      din = d;
      frame_start = fs;
      @(posedge clk);
      #1;
   endtask

   task automatic send_slots(input logic [15:0] w, input int n, input int gap, input logic exp_fe);
      logic [3:0] es;
      for (int i = 0; i < n; i++) begin
         put(1'b1, w[i], i == 0);
         es = (i == 15) ? (PAR ? 4'd15 : 4'd0) : 4'(i + 1);
         checks++;
         if (s !== es) begin
            errors++;
            $display("FAIL slot_index: slot %0d s=%0d required %0d", i, s, es);
         end
         if (i == 0) begin
            checks++;
            if (frame_err !== exp_fe) begin
               errors++;
               $display("FAIL frame_start_err: frame_err=%b required %b", frame_err, exp_fe);
            end
         end
         if (i < 15 && gap > 0) begin
            for (int g = 0; g < gap; g++) put(1'b0, 1'b1, 1'b1);
            checks++;
            if (s !== es) begin
               errors++;
               $display("FAIL gap_hold: s=%0d required %0d", s, es);
            end
         end
      end
   endtask

   task automatic send_frame(input logic [15:0] w, input int gap, input logic exp_fe);
      exp_q.push_back(w);
      send_slots(w, 16, gap, exp_fe);
      if (PAR) put(1'b1, ^w, 1'b0);
      checks++;
      if (dout_valid !== 1'b1 || frame_err !== 1'b0 || s !== 4'd0) begin
         errors++;
         $display("FAIL commit: dout_valid=%b frame_err=%b s=%0d required 1 0 0", dout_valid, frame_err, s);
      end
      put(1'b0, 1'b0, 1'b0);
      checks++;
      if (dout_valid !== 1'b0) begin
         errors++;
         $display("FAIL strobe_width: dout_valid=%b required 0", dout_valid);
      end
   endtask

   task automatic test_reset;
      rst = 1;
      put(1'b0, 1'b0, 1'b0);
      put(1'b0, 1'b0, 1'b0);
      rst = 0;
      checks++;
      if (s !== 4'd0 || dataout !== 16'h0 || dout_valid !== 1'b0 || frame_err !== 1'b0) begin
         errors++;
         $display("FAIL reset: s=%0d dataout=%h dv=%b fe=%b required 0 0000 0 0", s, dataout, dout_valid, frame_err);
      end
   endtask

   task automatic test_back_to_back;
      int d0 = dv_cnt;
      send_frame(16'h000F, 0, 1'b0);
      checks++;
      if (dataout !== 16'h000F || dv_cnt - d0 != 1) begin
         errors++;
         $display("FAIL back_to_back: dataout=%h strobes=%0d required 000f 1", dataout, dv_cnt - d0);
      end
   endtask

   task automatic test_gaps;
      int d0 = dv_cnt;
      send_frame(16'h001E, 3, 1'b0);
      checks++;
      if (dataout !== 16'h001E || dv_cnt - d0 != 1) begin
         errors++;
         $display("FAIL gaps: dataout=%h strobes=%0d required 001e 1", dataout, dv_cnt - d0);
      end
   endtask

   task automatic test_abort;
      int d0 = dv_cnt;
      int f0 = fe_cnt;
      send_slots(16'hFFFF, 8, 0, 1'b0);
      send_frame(16'h00AA, 0, 1'b1);
      checks++;
      if (dataout !== 16'h00AA || dv_cnt - d0 != 1 || fe_cnt - f0 != 1) begin
         errors++;
         $display("FAIL abort: dataout=%h strobes=%0d errs=%0d required 00aa 1 1", dataout, dv_cnt - d0, fe_cnt - f0);
      end
   endtask

   task automatic test_idle_ignore;
      int d0 = dv_cnt;
      int f0 = fe_cnt;
      for (int i = 0; i < 5; i++) begin
         put(1'b1, 1'(i), 1'b0);
         checks++;
         if (s !== 4'd0) begin
            errors++;
            $display("FAIL idle_s: s=%0d required 0", s);
         end
      end
      put(1'b0, 1'b0, 1'b0);
      checks++;
      if (dataout !== 16'h00AA || dv_cnt != d0 || fe_cnt != f0) begin
         errors++;
         $display("FAIL idle_ignore: dataout=%h strobes=%0d errs=%0d required 00aa 0 0", dataout, dv_cnt - d0, fe_cnt - f0);
      end
   endtask

   task automatic test_reset_mid_frame;
      int d0 = dv_cnt;
      int f0 = fe_cnt;
      send_slots(16'h1234, 10, 0, 1'b0);
      rst = 1;
      put(1'b0, 1'b0, 1'b0);
      rst = 0;
      put(1'b0, 1'b0, 1'b0);
      checks++;
      if (dataout !== 16'h0 || s !== 4'd0 || dv_cnt != d0 || fe_cnt != f0) begin
         errors++;
         $display("FAIL reset_mid_frame: dataout=%h s=%0d strobes=%0d errs=%0d required 0000 0 0 0", dataout, s, dv_cnt - d0, fe_cnt - f0);
      end
      send_frame(16'h5678, 0, 1'b0);
      checks++;
      if (dataout !== 16'h5678) begin
         errors++;
         $display("FAIL after_reset: dataout=%h required 5678", dataout);
      end
   endtask

`ifdef PARITY_CHECK_EN
   task automatic test_parity;
      send_frame(16'h000F, 0, 1'b0);
      send_slots(16'h0007, 16, 0, 1'b0);
      put(1'b1, 1'b0, 1'b0);
      checks++;
      if (frame_err !== 1'b1 || dout_valid !== 1'b0 || dataout !== 16'h000F || s !== 4'd0) begin
         errors++;
         $display("FAIL parity_bad: fe=%b dv=%b dataout=%h s=%0d required 1 0 000f 0", frame_err, dout_valid, dataout, s);
      end
      put(1'b0, 1'b0, 1'b0);
   endtask
`endif

   initial begin
      test_reset;
      test_back_to_back;
      test_gaps;
      test_abort;
      test_idle_ignore;
      test_reset_mid_frame;
`ifdef PARITY_CHECK_EN
      test_parity;
`endif
      put(1'b0, 1'b0, 1'b0);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d words pending required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
